// File: rtl/n64_poll_scheduler.sv
// APB-programmable poll scheduler: periodic tick, round-robin port selection and
// timeout-bounded transactions on one shared N64 transceiver, with per-port result capture.
module n64_poll_scheduler #(
  parameter int NUM_PORTS      = 2,
  parameter int DEFAULT_PERIOD = 100000,
  parameter int TIMEOUT_CYCLES = 4000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        eng_start,
  input  logic        eng_done,
  input  logic [31:0] eng_data,
  output logic [1:0]  port_sel,
  output logic        irq
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_START, S_WAIT, S_NEXT} state_t;

  state_t                state_q, state_d;
  logic                  enable_q, irq_en_q, overrun_q, irq_q;
  logic [NUM_PORTS-1:0]  mask_q, valid_q, timeout_q, round_mask_q, round_mask_d;
  logic [19:0]           period_q, cnt_q;
  logic [31:0]           data_q [NUM_PORTS];
  logic [1:0]            port_sel_q, port_sel_d, last_q, last_d;
  logic [TW-1:0]         tocnt_q, tocnt_d;
  logic                  done_hit, to_hit, run, tick, found;
  int                    idx;

  logic [7:0] addr;
  logic [1:0] data_idx;
  logic       access, wr_en, rd_en, hit_ctrl, hit_period, hit_status, hit_data;
  logic       unused_bits;

  assign addr        = PADDR[7:0];
  assign data_idx    = addr[3:2];
  assign access      = PSEL & PENABLE;
  assign wr_en       = access & PWRITE;
  assign rd_en       = access & ~PWRITE;
  assign hit_ctrl    = (addr == 8'h00);
  assign hit_period  = (addr == 8'h04);
  assign hit_status  = (addr == 8'h08);
  assign hit_data    = (addr[7:4] == 4'h1) && (addr[1:0] == 2'b00) && (int'(data_idx) < NUM_PORTS);
  assign PREADY      = 1'b1;
  assign PSLVERR     = access & ~(hit_ctrl | hit_period | hit_status | hit_data);
  assign port_sel    = port_sel_q;
  assign irq         = irq_q;
  assign unused_bits = ^{PADDR[31:8], PWDATA[31:20]};

  always_comb begin
    PRDATA = '0;
    if (access) begin
      if (hit_ctrl) begin
        PRDATA[0]             = enable_q;
        PRDATA[1]             = irq_en_q;
        PRDATA[8 +: NUM_PORTS] = mask_q;
      end else if (hit_period) begin
        PRDATA[19:0] = period_q;
      end else if (hit_status) begin
        PRDATA[0 +: NUM_PORTS] = valid_q;
        PRDATA[8 +: NUM_PORTS] = timeout_q;
        PRDATA[16]             = overrun_q;
        PRDATA[17]             = (state_q != S_IDLE);
      end else if (hit_data) begin
        for (int i = 0; i < NUM_PORTS; i++)
          if (data_idx == 2'(i)) PRDATA = data_q[i];
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      mask_q   <= '0;
      period_q <= 20'(DEFAULT_PERIOD);
    end else if (wr_en) begin
      if (hit_ctrl) begin
        enable_q <= PWDATA[0];
        irq_en_q <= PWDATA[1];
        mask_q   <= PWDATA[8 +: NUM_PORTS];
      end
      if (hit_period) period_q <= PWDATA[19:0];
    end
  end

  assign run  = enable_q && (period_q != 20'd0);
  assign tick = run && (cnt_q == period_q - 20'd1);

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN)                      cnt_q <= '0;
    else if (wr_en && hit_period)      cnt_q <= '0;
    else if (!run || tick)             cnt_q <= '0;
    else                               cnt_q <= cnt_q + 20'd1;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q      <= S_IDLE;
      round_mask_q <= '0;
      port_sel_q   <= '0;
      last_q       <= 2'(NUM_PORTS - 1);
      tocnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      round_mask_q <= round_mask_d;
      port_sel_q   <= port_sel_d;
      last_q       <= last_d;
      tocnt_q      <= tocnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    round_mask_d = round_mask_q;
    port_sel_d   = port_sel_q;
    last_d       = last_q;
    tocnt_d      = tocnt_q;
    done_hit     = 1'b0;
    to_hit       = 1'b0;
    eng_start    = 1'b0;
    found        = 1'b0;
    idx          = 0;
    case (state_q)
      S_IDLE: begin
        if (tick && (mask_q != '0)) begin
          round_mask_d = mask_q;
          state_d      = S_SELECT;
        end
      end
      S_SELECT: begin
        // Search starts just after the last-served port so every masked port gets a turn.
        for (int k = 1; k <= NUM_PORTS; k++) begin
          idx = (int'(last_q) + k) % NUM_PORTS;
          if (!found && round_mask_q[idx]) begin
            found             = 1'b1;
            port_sel_d        = 2'(idx);
            last_d            = 2'(idx);
            round_mask_d[idx] = 1'b0;
          end
        end
        state_d = S_START;
      end
      S_START: begin
        eng_start = 1'b1;
        tocnt_d   = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        tocnt_d = tocnt_q + 1'b1;
        if (eng_done) begin
          done_hit = 1'b1;
          state_d  = S_NEXT;
        end else if (tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_hit  = 1'b1;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        state_d = ((round_mask_q != '0) && enable_q) ? S_SELECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Hardware capture/set takes priority over a same-cycle read-clear or w1c.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      valid_q   <= '0;
      timeout_q <= '0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (done_hit && (port_sel_q == 2'(i))) begin
          data_q[i]    <= eng_data;
          valid_q[i]   <= 1'b1;
          timeout_q[i] <= 1'b0;
        end else begin
          if (rd_en && hit_data && (data_idx == 2'(i))) valid_q[i] <= 1'b0;
          if (to_hit && (port_sel_q == 2'(i)))          timeout_q[i] <= 1'b1;
          else if (wr_en && hit_status && PWDATA[8+i])  timeout_q[i] <= 1'b0;
        end
      end
      if (tick && (state_q != S_IDLE))             overrun_q <= 1'b1;
      else if (wr_en && hit_status && PWDATA[16])  overrun_q <= 1'b0;
      irq_q <= irq_en_q & ((|valid_q) | (|timeout_q) | overrun_q);
    end
  end
endmodule

// File: tb/tb_n64_poll_scheduler.sv
// Bench for n64_poll_scheduler: APB driver, transceiver model and a queue of expected
// eng_start port indices popped whenever the scheduler starts a transaction.
module tb_n64_poll_scheduler;
  localparam int NUM_PORTS      = 2;
  localparam int DEFAULT_PERIOD = 100000;
  localparam int TIMEOUT_CYCLES = 4000;

  logic        PCLK = 1'b0, PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = '0, PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, eng_start, irq;
  logic        eng_done = 1'b0;
  logic [31:0] eng_data = '0;
  logic [1:0]  port_sel;

  int          tests = 0, fails = 0;
  int          exp_port_q[$];
  int          start_count = 0;
  bit          resp_en = 1'b1;
  int          resp_delay = 30;
  int          resp_cnt = 0;
  logic [1:0]  resp_port = '0;
  logic [31:0] resp_tag = '0;

  n64_poll_scheduler #(
    .NUM_PORTS(NUM_PORTS), .DEFAULT_PERIOD(DEFAULT_PERIOD), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .eng_start(eng_start), .eng_done(eng_done), .eng_data(eng_data), .port_sel(port_sel),
    .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  // Transceiver model and start scoreboard.
  always @(negedge PCLK) begin
    int e;
    eng_done = 1'b0;
    if (!PRESERN) begin
      resp_cnt = 0;
    end else if (eng_start) begin
      start_count++;
      tests++;
      if (exp_port_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_start: port_sel=%0d, no start expected", port_sel);
      end else begin
        e = exp_port_q.pop_front();
        if (port_sel !== 2'(e)) begin
          fails++;
          $display("FAIL start_port: port_sel=%0d expected %0d", port_sel, e);
        end
      end
      $display("[TB] eng_start #%0d port_sel=%0d", start_count, port_sel);
      if (resp_en) begin
        resp_cnt  = resp_delay;
        resp_port = port_sel;
      end
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        eng_done = 1'b1;
        eng_data = 32'hA5A5_0000 + resp_tag + {30'b0, resp_port};
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = {24'h0, a}; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    $display("[TB] write 0x%02h <= 0x%08h", a, d);
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = {24'h0, a};
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    d = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("[TB] read 0x%02h => 0x%08h slverr=%0b", a, d, err);
  endtask

  task automatic wait_starts(input int target, input int limit, output bit ok);
    int n = 0;
    while (start_count < target && n < limit) begin
      @(negedge PCLK);
      n++;
    end
    ok = (start_count >= target);
  endtask

  task automatic test_reset();
    logic [7:0]  addrs [5] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14};
    logic [31:0] exps  [5] = '{32'h0, 32'd100000, 32'h0, 32'h0, 32'h0};
    logic [31:0] d;
    logic        e;
    repeat (3) @(negedge PCLK);
    tests++;
    if ({eng_start, port_sel, irq, PREADY} !== 5'b0_00_0_1 || PRDATA !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: start=%0b sel=%0d irq=%0b ready=%0b prdata=%h, expected 0 0 0 1 0",
               eng_start, port_sel, irq, PREADY, PRDATA);
    end
    PRESERN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], d, e);
      tests++;
      if (d !== exps[i] || e !== 1'b0) begin
        fails++;
        $display("FAIL reset_reg_%02h: got %h err %0b, expected %h err 0", addrs[i], d, e, exps[i]);
      end
    end
    apb_read(8'h40, d, e);
    tests++;
    if (d !== 32'h0 || e !== 1'b1) begin
      fails++;
      $display("FAIL unmapped_read: got %h err %0b, expected 0 err 1", d, e);
    end
    apb_write(8'h00, 32'h0000_0F02);
    apb_read(8'h00, d, e);
    tests++;
    if (d !== 32'h0000_0302) begin
      fails++;
      $display("FAIL ctrl_mask_width: got %h expected 00000302", d);
    end
    apb_write(8'h00, 32'h0);
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    logic        e;
    bit          ok;
    int          base = start_count;
    resp_tag = 32'h0; resp_en = 1'b1; resp_delay = 30;
    exp_port_q.push_back(0);
    exp_port_q.push_back(1);
    apb_write(8'h04, 32'd50);
    apb_write(8'h00, 32'h0000_0303);
    wait_starts(base + 2, 200, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL rr_starts: got %0d starts, expected 2", start_count - base);
    end
    apb_write(8'h00, 32'h0000_0302);
    repeat (40) @(negedge PCLK);
    tests++;
    if (start_count - base !== 2) begin
      fails++;
      $display("FAIL rr_start_count: got %0d expected 2", start_count - base);
    end
    apb_read(8'h08, d, e);
    tests++;
    if (d !== 32'h0000_0003) begin
      fails++;
      $display("FAIL rr_status: got %h expected 00000003", d);
    end
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL rr_irq: got %0b expected 1", irq);
    end
    apb_read(8'h10, d, e);
    tests++;
    if (d !== 32'hA5A5_0000) begin
      fails++;
      $display("FAIL rr_data0: got %h expected a5a50000", d);
    end
    apb_read(8'h08, d, e);
    tests++;
    if (d !== 32'h0000_0002) begin
      fails++;
      $display("FAIL rr_valid_clear: got %h expected 00000002", d);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic        e;
    int          n;
    apb_read(8'h14, d, e);
    tests++;
    if (d !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL to_data1_before: got %h expected a5a50001", d);
    end
    resp_en = 1'b0;
    exp_port_q.push_back(1);
    apb_write(8'h04, 32'd5000);
    apb_write(8'h00, 32'h0000_0203);
    n = 0;
    while (!eng_start && n < 6000) begin
      @(negedge PCLK);
      n++;
    end
    tests++;
    if (eng_start !== 1'b1 || irq !== 1'b0) begin
      fails++;
      $display("FAIL to_start: start=%0b irq=%0b, expected start 1 irq 0", eng_start, irq);
    end
    // START cycle, then TIMEOUT_CYCLES in WAIT, then one cycle each for status and irq.
    n = 0;
    while (!irq && n < TIMEOUT_CYCLES + 100) begin
      @(negedge PCLK);
      n++;
    end
    tests++;
    if (n !== TIMEOUT_CYCLES + 2) begin
      fails++;
      $display("FAIL to_latency: irq after %0d cycles, expected %0d", n, TIMEOUT_CYCLES + 2);
    end
    apb_write(8'h00, 32'h0000_0202);
    apb_read(8'h08, d, e);
    tests++;
    if (d !== 32'h0000_0200) begin
      fails++;
      $display("FAIL to_status: got %h expected 00000200", d);
    end
    apb_read(8'h14, d, e);
    tests++;
    if (d !== 32'hA5A5_0001) begin
      fails++;
      $display("FAIL to_data1_kept: got %h expected a5a50001", d);
    end
    apb_write(8'h08, 32'h0000_0200);
    repeat (2) @(negedge PCLK);
    apb_read(8'h08, d, e);
    tests++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL to_w1c: status %h irq %0b, expected 0 and 0", d, irq);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic        e;
    bit          ok;
    int          base = start_count;
    resp_tag = 32'h0000_0200;
    apb_write(8'h04, 32'd20);
    exp_port_q.push_back(0);
    apb_write(8'h00, 32'h0000_0101);
    wait_starts(base + 1, 100, ok);
    repeat (20) @(negedge PCLK);
    apb_write(8'h00, 32'h0000_0100);
    repeat (50) @(negedge PCLK);
    apb_read(8'h08, d, e);
    tests++;
    if (!ok || start_count - base !== 1 || d[16] !== 1'b1 || d[17] !== 1'b0) begin
      fails++;
      $display("FAIL ovr_first: starts %0d status %h, expected 1 start and overrun set, idle",
               start_count - base, d);
    end
    // Last-served is now port 0, so the two-port round must begin at port 1.
    exp_port_q.push_back(1);
    exp_port_q.push_back(0);
    apb_write(8'h00, 32'h0000_0301);
    wait_starts(base + 3, 200, ok);
    apb_write(8'h00, 32'h0000_0300);
    repeat (50) @(negedge PCLK);
    tests++;
    if (!ok || start_count - base !== 3 || exp_port_q.size() != 0) begin
      fails++;
      $display("FAIL ovr_second: starts %0d pending %0d, expected 3 and 0",
               start_count - base, exp_port_q.size());
    end
    apb_read(8'h10, d, e);
    tests++;
    if (d !== 32'hA5A5_0200) begin
      fails++;
      $display("FAIL ovr_data0: got %h expected a5a50200", d);
    end
    apb_read(8'h14, d, e);
    tests++;
    if (d !== 32'hA5A5_0201) begin
      fails++;
      $display("FAIL ovr_data1: got %h expected a5a50201", d);
    end
    apb_write(8'h08, 32'h0001_0000);
  endtask

  task automatic test_disable_mid_wait();
    logic [31:0] d;
    logic        e;
    bit          ok;
    int          base = start_count;
    resp_tag = 32'h0000_0100;
    apb_write(8'h04, 32'd50);
    exp_port_q.push_back(1);
    apb_write(8'h00, 32'h0000_0301);
    wait_starts(base + 1, 100, ok);
    apb_write(8'h00, 32'h0000_0300);
    repeat (150) @(negedge PCLK);
    tests++;
    if (!ok || start_count - base !== 1) begin
      fails++;
      $display("FAIL dis_starts: got %0d expected 1", start_count - base);
    end
    apb_read(8'h08, d, e);
    tests++;
    if (d !== 32'h0000_0002) begin
      fails++;
      $display("FAIL dis_status: got %h expected 00000002", d);
    end
    apb_read(8'h14, d, e);
    tests++;
    if (d !== 32'hA5A5_0101) begin
      fails++;
      $display("FAIL dis_data1: got %h expected a5a50101", d);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d;
    logic        e;
    int          n;
    int          base;
    exp_port_q.push_back(1);
    apb_write(8'h00, 32'h0000_0201);
    n = 0;
    while (!eng_start && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    #1;
    PRESERN = 1'b0;
    #1;
    tests++;
    if (eng_start !== 1'b0 || port_sel !== 2'd0 || irq !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: start=%0b sel=%0d irq=%0b, expected all 0", eng_start, port_sel, irq);
    end
    repeat (3) @(negedge PCLK);
    PRESERN = 1'b1;
    apb_read(8'h08, d, e);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL rst_status: got %h expected 0", d);
    end
    apb_read(8'h00, d, e);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL rst_ctrl: got %h expected 0", d);
    end
    base = start_count;
    repeat (200) @(negedge PCLK);
    tests++;
    if (start_count !== base) begin
      fails++;
      $display("FAIL rst_no_start: got %0d starts expected 0", start_count - base);
    end
    exp_port_q.push_back(0);
    apb_write(8'h04, 32'd30);
    apb_write(8'h00, 32'h0000_0101);
    n = 0;
    while (!eng_start && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    tests++;
    if (n !== 32) begin
      fails++;
      $display("FAIL tick_latency: start after %0d cycles expected 32", n);
    end
    apb_write(8'h00, 32'h0);
    repeat (40) @(negedge PCLK);
    tests++;
    if (exp_port_q.size() != 0) begin
      fails++;
      $display("FAIL pending_starts: got %0d expected 0", exp_port_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_overrun();
    test_disable_mid_wait();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
- APB-programmable scheduler that sequences the single-wire N64 poll transceiver and shares it among up to NUM_PORTS controller ports.
- Generates the periodic poll tick, picks ports round-robin, starts one transaction at a time and bounds it with a timeout.
- Stores each port's 32-bit result with valid/timeout status and raises an interrupt.
- Sits between the APB bus and the bit-level transceiver; the transceiver's io pin mux is steered by port_sel.

Parameters:
NUM_PORTS, 2, number of controller ports sharing the transceiver (1..4)
DEFAULT_PERIOD, 100000, poll period in PCLK cycles after reset
TIMEOUT_CYCLES, 4000, max PCLK cycles from eng_start to eng_done before abort

Ports:
PCLK  in  1  system clock
PRESERN  in  1  reset, asynchronous, active-low
PSEL  in  1  APB peripheral select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write/read
PADDR  in  32  APB address; only [7:0] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  APB ready; constant 1, zero wait states
PSLVERR  out  1  APB error; 1 during access phase to an unmapped address
eng_start  out  1  one-cycle pulse that starts one poll transaction
eng_done  in  1  one-cycle pulse from transceiver; eng_data valid in the same cycle
eng_data  in  32  received controller word
port_sel  out  2  index of the port routed to the transceiver
irq  out  1  level interrupt

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL rw: [0] enable, [1] irq_en, [11:8] port mask. Reset: enable=0, irq_en=0, mask=0.
  - 0x04 PERIOD rw: [19:0]; reset DEFAULT_PERIOD; 0 stops ticks.
  - 0x08 STATUS: [3:0] valid (ro), [11:8] timeout (w1c), [16] overrun (w1c), [17] busy (ro).
  - 0x10+4*i DATA_i ro: reading clears valid[i].
- Any other offset: PSLVERR=1; write ignored; PRDATA=0.
- Mask bits at or above NUM_PORTS read 0 and are ignored.
- APB writes take effect on the PENABLE cycle. PRDATA is combinational from PADDR during the access phase.
- Reset values: PRDATA=0, eng_start=0, port_sel=0, irq=0, all DATA=0, all STATUS bits 0, period counter 0, last-served port = NUM_PORTS-1.
- Period counter:
  - Runs only while enable=1 and PERIOD!=0; otherwise held at 0.
  - When count == PERIOD-1: one-cycle tick, count wraps to 0.
  - A write to PERIOD resets count to 0.
- FSM states IDLE, SELECT, START, WAIT, NEXT:
  - IDLE: tick && (mask!=0) -> SELECT and latch round_mask=mask. Otherwise stay in IDLE.
  - SELECT: port_sel <= first set bit of round_mask searching upward from last-served+1 (mod NUM_PORTS). Clear that bit in round_mask, update last-served, go to START.
  - START: eng_start=1 for exactly this cycle, timeout counter cleared -> WAIT.
  - WAIT, on eng_done: DATA[port_sel] <= eng_data, valid[port_sel] <= 1, timeout[port_sel] <= 0 -> NEXT.
  - WAIT, on timeout counter reaching TIMEOUT_CYCLES-1 without eng_done: timeout[port_sel] <= 1, DATA unchanged -> NEXT.
  - WAIT, eng_done on the timeout cycle: treated as done.
  - NEXT: round_mask!=0 and enable=1 -> SELECT; else IDLE.
- Latency: tick to eng_start = 2 cycles (SELECT, START).
- busy=1 in every state except IDLE.
- port_sel changes only in SELECT and is held through WAIT/NEXT.
- A tick while not in IDLE sets overrun and is dropped. Rounds never queue.
- Clearing enable mid-round: the current WAIT completes normally, then the FSM returns to IDLE. No further eng_start.
- Mask changes mid-round affect the next round only.
- eng_done outside WAIT is ignored.
- Simultaneous APB read of DATA_i and capture into DATA_i: PRDATA returns the old value and valid[i] ends at 1 (capture wins).
- Simultaneous w1c of a timeout/overrun bit and a hardware set of the same bit: the set wins.
- irq = irq_en & (|valid | |timeout | overrun), registered (one cycle after the cause).
- Reset asserted mid-transaction: all state returns to reset values immediately. eng_start drops asynchronously.

Test Plan:
- Reset, then read all registers -> CTRL=0, PERIOD=100000, STATUS=0, DATA_0=DATA_1=0; PREADY=1, PSLVERR=0; read 0x40 -> PSLVERR=1, PRDATA=0.
- PERIOD=50, CTRL=0x301; transceiver answers eng_done 30 cycles after each start with 0xA5A50000+port -> each tick produces port_sel 0 then 1, exactly one eng_start per port; DATA_0=0xA5A50000, DATA_1=0xA5A50001, valid=0x3. Reading DATA_0 clears valid[0] only.
- Mask=0x2, transceiver never responds -> eng_start at tick+2, timeout[1]=1 exactly 4000 cycles later, DATA_1 unchanged; with irq_en=1, irq=1 next cycle; w1c 0x200 to STATUS clears it and irq drops.
- PERIOD=20 with 30-cycle responses on two ports -> overrun=1, no eng_start issued while busy, the next round starts from the port after last-served.
- Clear enable during WAIT -> done captured, FSM returns to IDLE, busy=0, no further eng_start for 3×PERIOD.
- Assert PRESERN low during WAIT -> eng_start=0, port_sel=0, STATUS=0 immediately; after release there is no start until the first tick with enable set.
